// File: rtl/rv32_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pipe_pkg
// Purpose  : Shared rv32 pipeline types, constants and PC helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV32_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    function automatic word_t align_pc(input word_t pc);
        return pc & INSTR_ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_fifo
// Purpose  : Power-of-two synchronous FIFO with clear, count and flags.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push    = push && !clear;
    assign w_pop     = pop && !clear && (r_count != '0);
    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= r_count + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : rv32 instruction fetch: PC, credit-limited imem requests,
//            response buffering and redirect flush with stale-drop counting.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(FIFO_DEPTH);

    word_t              r_pc;
    logic [c_cnt_w-1:0] r_drop;
    logic [c_cnt_w-1:0] w_outstanding;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic [c_cnt_w:0]   w_credit_used;
    logic               w_accept;
    logic               w_rsp;
    logic               w_keep;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic               w_sideq_empty;
    logic               w_sideq_full;
    word_t              w_rsp_pc;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    // Requests in flight plus buffered words may never exceed the buffer
    // size, so every returning word is guaranteed a slot.
    assign w_credit_used  = {1'b0, w_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < c_depth);
    assign imem_req_addr  = r_pc;

    assign w_accept = imem_req_valid && imem_req_ready;
    assign w_rsp    = imem_rsp_valid && !w_sideq_empty;
    assign w_keep   = w_rsp && !redirect_valid && (r_drop == '0);
    assign w_pop    = id_valid && id_ready && !redirect_valid;

    assign w_push_entry = '{pc: w_rsp_pc, instr: imem_rsp_data};

    // The PC queue tracks in-flight requests; its count is the outstanding
    // total and it is deliberately not flushed on redirect.
    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .push      (w_accept),
        .push_data (r_pc),
        .pop       (w_rsp),
        .head_data (w_rsp_pc),
        .count     (w_outstanding),
        .empty     (w_sideq_empty),
        .full      (w_sideq_full)
    );

    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (w_keep),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    assign id_valid       = !w_fifo_empty;
    assign id_instruction = id_valid ? w_head.instr : RV32_NOP;
    assign id_pc          = id_valid ? w_head.pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_drop <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle is stale.
            r_pc   <= align_pc(redirect_pc);
            r_drop <= w_outstanding - c_cnt_w'(w_rsp);
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_rsp && (r_drop != '0)) begin
                r_drop <= r_drop - c_cnt_w'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> !w_sideq_empty);
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_keep |-> !w_fifo_full);
    a_no_sideq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_accept |-> !w_sideq_full);
`endif

endmodule
`default_nettype wire
